imem_responder: RTL and testbench

Instruction-memory responder serving the fetch stage's memory interface. Accepts word fetch requests over a valid/ready handshake, reads a synchronous instruction RAM through a configurable-latency pipeline, and returns instructions in request order through a first-word-fall-through response FIFO. Supports a flush that drops all in-flight fetches on a redirect, plus a write port for program loading.

---
 rtl/imem_responder.sv | 158 +++++++++++++++
 tb/tb_imem_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// imem_responder: instruction-memory fetch responder. Fetch requests read a synchronous
// instruction RAM through a LATENCY-cycle pipeline. The pipeline writes into a
// first-word-fall-through response FIFO, so responses come back in request order.
// Optional feature macro: IMEM_MISALIGN_FAULT_EN. When it is defined, misaligned
// fetches return a fault flag together with a NOP.
module imem_responder #(
  parameter int DEPTH      = 4096,
  parameter int LATENCY    = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_flush,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [63:0] i_req_addr,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_instr,
  output logic [63:0] o_rsp_addr,
  output logic        o_rsp_fault,
  input  logic        i_wr_en,
  input  logic [63:0] i_wr_addr,
  input  logic [31:0] i_wr_data
);
  localparam int IW = $clog2(DEPTH);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0033;

  // RAM powers up holding NOPs; reset never touches it.
  logic [31:0] mem [DEPTH] = '{default: NOP};

  logic [IW-1:0] rd_idx;
  logic [IW-1:0] wr_idx;
  logic          acc;
  logic          pop;
  logic [OW-1:0] outstanding;

  // Entry leaving the read pipeline at the next edge.
  logic          pipe_vld;
  logic [31:0]   pipe_instr;
  logic [63:0]   pipe_addr;
`ifdef IMEM_MISALIGN_FAULT_EN
  logic          pipe_fault;
  logic          fifo_fault [FIFO_DEPTH];
`endif

  logic [31:0]   fifo_instr [FIFO_DEPTH];
  logic [63:0]   fifo_addr  [FIFO_DEPTH];
  logic [FW:0]   wptr;
  logic [FW:0]   rptr;
  logic [FW-1:0] rslot;
  logic          unused_wr_bits;

  assign rd_idx         = i_req_addr[2 +: IW];
  assign wr_idx         = i_wr_addr[2 +: IW];
  assign unused_wr_bits = ^{i_wr_addr[63:2+IW], i_wr_addr[1:0]};

  // outstanding is a register, so the consumer's ready has no combinational path to o_req_ready.
  assign o_req_ready = !i_rst && !i_flush && (outstanding < OW'(FIFO_DEPTH));
  assign acc         = i_req_valid && o_req_ready;
  assign o_rsp_valid = (wptr != rptr);
  assign pop         = o_rsp_valid && i_rsp_ready;
  assign rslot       = rptr[FW-1:0];

  // Program-load write port; a same-edge read of the same word still sees the old value.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem[wr_idx] <= i_wr_data;
  end

  generate
    if (LATENCY == 1) begin : g_lat1
      // The capture edge writes the RAM word straight into the FIFO.
      assign pipe_vld   = acc;
      assign pipe_instr = mem[rd_idx];
      assign pipe_addr  = i_req_addr;
`ifdef IMEM_MISALIGN_FAULT_EN
      assign pipe_fault = |i_req_addr[1:0];
`endif
    end else begin : g_latn
      logic        vld_p   [LATENCY-1];
      logic [31:0] instr_p [LATENCY-1];
      logic [63:0] addr_p  [LATENCY-1];
`ifdef IMEM_MISALIGN_FAULT_EN
      logic        fault_p [LATENCY-1];
`endif

      // Data stages: the RAM read register, then delay stages. These stages have no reset.
      always_ff @(posedge i_clk) begin
        instr_p[0] <= mem[rd_idx];
        addr_p[0]  <= i_req_addr;
`ifdef IMEM_MISALIGN_FAULT_EN
        fault_p[0] <= |i_req_addr[1:0];
`endif
        for (int k = 1; k < LATENCY - 1; k++) begin
          instr_p[k] <= instr_p[k-1];
          addr_p[k]  <= addr_p[k-1];
`ifdef IMEM_MISALIGN_FAULT_EN
          fault_p[k] <= fault_p[k-1];
`endif
        end
      end

      // Valid stages: reset and flush clear them, so dropped fetches never reach the FIFO.
      always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
          for (int k = 0; k < LATENCY - 1; k++) vld_p[k] <= 1'b0;
        end else begin
          vld_p[0] <= acc;
          for (int k = 1; k < LATENCY - 1; k++) vld_p[k] <= vld_p[k-1];
        end
      end

      assign pipe_vld   = vld_p[LATENCY-2];
      assign pipe_instr = instr_p[LATENCY-2];
      assign pipe_addr  = addr_p[LATENCY-2];
`ifdef IMEM_MISALIGN_FAULT_EN
      assign pipe_fault = fault_p[LATENCY-2];
`endif
    end
  endgenerate

  // FIFO payload: written as an entry leaves the pipeline. A faulting fetch stores a NOP.
  always_ff @(posedge i_clk) begin
    if (pipe_vld) begin
      fifo_addr[wptr[FW-1:0]]  <= pipe_addr;
`ifdef IMEM_MISALIGN_FAULT_EN
      fifo_instr[wptr[FW-1:0]] <= pipe_fault ? NOP : pipe_instr;
      fifo_fault[wptr[FW-1:0]] <= pipe_fault;
`else
      fifo_instr[wptr[FW-1:0]] <= pipe_instr;
`endif
    end
  end

  // FIFO pointers and the outstanding count. Reset and flush drop everything in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      wptr        <= '0;
      rptr        <= '0;
      outstanding <= '0;
    end else begin
      if (pipe_vld) wptr <= wptr + 1'b1;
      if (pop)      rptr <= rptr + 1'b1;
      outstanding <= outstanding + OW'(acc) - OW'(pop);
    end
  end

  assign o_rsp_instr = o_rsp_valid ? fifo_instr[rslot] : '0;
  assign o_rsp_addr  = o_rsp_valid ? fifo_addr[rslot]  : '0;
`ifdef IMEM_MISALIGN_FAULT_EN
  assign o_rsp_fault = o_rsp_valid && fifo_fault[rslot];
`else
  assign o_rsp_fault = 1'b0;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Testbench for imem_responder. It runs a directed vector table, hand-written corner
// sequences and random traffic. A queue-based reference model checks every cycle.
module tb_imem_responder;
  localparam int DEPTH      = 4096;
  localparam int LATENCY    = 1;
  localparam int FIFO_DEPTH = 2;
  localparam int IW         = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0033;

  logic        clk = 1'b0;
  logic        rst, flush, req_valid, rsp_ready, wr_en;
  logic [63:0] req_addr, wr_addr;
  logic [31:0] wr_data;
  logic        o_req_ready, o_rsp_valid, o_rsp_fault;
  logic [31:0] o_rsp_instr;
  logic [63:0] o_rsp_addr;

  imem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_req_valid(req_valid), .o_req_ready(o_req_ready), .i_req_addr(req_addr),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_instr(o_rsp_instr), .o_rsp_addr(o_rsp_addr), .o_rsp_fault(o_rsp_fault),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a word array plus an ordered queue of promised responses.
  typedef struct {
    logic [63:0] addr;
    logic [31:0] instr;
    logic        fault;
    int          rdy;
  } exp_t;
  exp_t        q[$];
  logic [31:0] mm [DEPTH];
  int          cyc = 0;

  typedef struct {
    logic rst, flush, rv; logic [63:0] ra; logic rr;
    logic we; logic [63:0] wa; logic [31:0] wd;
    logic e_ready, e_valid; logic [31:0] e_instr; logic [63:0] e_addr;
  } vec_t;
  vec_t vt [16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic drv(input logic r, input logic f, input logic rv, input logic [63:0] ra,
                     input logic rr, input logic we, input logic [63:0] wa, input logic [31:0] wd);
    rst = r; flush = f; req_valid = rv; req_addr = ra; rsp_ready = rr;
    wr_en = we; wr_addr = wa; wr_data = wd;
  endtask

  function automatic logic mis(input logic [63:0] a);
`ifdef IMEM_MISALIGN_FAULT_EN
    return |a[1:0];
`else
    return 1'b0;
`endif
  endfunction

  // One clock cycle: check the outputs against the model, then advance both across the edge.
  task automatic step();
    logic er, ev;
    exp_t h, n;
    #1;
    er = !rst && !flush && (q.size() < FIFO_DEPTH);
    ev = (q.size() > 0) && (q[0].rdy <= cyc);
    h  = '{addr: 64'h0, instr: 32'h0, fault: 1'b0, rdy: 0};
    if (ev) h = q[0];
    chk("m_req_ready", 64'(o_req_ready), 64'(er));
    chk("m_rsp_valid", 64'(o_rsp_valid), 64'(ev));
    chk("m_rsp_instr", 64'(o_rsp_instr), 64'(h.instr));
    chk("m_rsp_addr",  o_rsp_addr, h.addr);
    chk("m_rsp_fault", 64'(o_rsp_fault), 64'(h.fault));
    @(posedge clk);
    cyc++;
    if (rst || flush) q.delete();
    else begin
      if (ev && rsp_ready) void'(q.pop_front());
      if (req_valid && er) begin
        n.addr  = req_addr;
        n.fault = mis(req_addr);
        n.instr = n.fault ? NOP : mm[req_addr[2 +: IW]];
        n.rdy   = cyc + LATENCY - 1;
        q.push_back(n);
      end
    end
    if (wr_en) mm[wr_addr[2 +: IW]] = wr_data;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc, lat;
    logic [63:0] ra;
    for (int i = 0; i < DEPTH; i++) mm[i] = NOP;

    //             rst   flush rv    ra            rr    we    wa        wd             er    ev    instr          addr
    vt[0]  = '{1'b1, 1'b0, 1'b0, 64'h0,      1'b1, 1'b0, 64'h0,  32'h0,        1'b0, 1'b0, 32'h0,        64'h0};
    vt[1]  = '{1'b0, 1'b0, 1'b1, 64'h0,      1'b1, 1'b0, 64'h0,  32'h0,        1'b1, 1'b0, 32'h0,        64'h0};
    vt[2]  = '{1'b0, 1'b0, 1'b1, 64'h4,      1'b1, 1'b0, 64'h0,  32'h0,        1'b1, 1'b1, NOP,          64'h0};
    vt[3]  = '{1'b0, 1'b0, 1'b1, 64'h8,      1'b1, 1'b0, 64'h0,  32'h0,        1'b1, 1'b1, NOP,          64'h4};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 64'h0,      1'b1, 1'b0, 64'h0,  32'h0,        1'b1, 1'b1, NOP,          64'h8};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 64'h0,      1'b1, 1'b0, 64'h0,  32'h0,        1'b1, 1'b0, 32'h0,        64'h0};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 64'h0,      1'b1, 1'b1, 64'h10, 32'h00208133, 1'b1, 1'b0, 32'h0,        64'h0};
    vt[7]  = '{1'b0, 1'b0, 1'b1, 64'h10,     1'b1, 1'b0, 64'h0,  32'h0,        1'b1, 1'b0, 32'h0,        64'h0};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 64'h0,      1'b1, 1'b0, 64'h0,  32'h0,        1'b1, 1'b1, 32'h00208133, 64'h10};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 64'h14,     1'b1, 1'b1, 64'h14, 32'h11111111, 1'b1, 1'b0, 32'h0,        64'h0};
    vt[10] = '{1'b0, 1'b0, 1'b0, 64'h0,      1'b1, 1'b0, 64'h0,  32'h0,        1'b1, 1'b1, NOP,          64'h14};
    vt[11] = '{1'b0, 1'b0, 1'b1, 64'h14,     1'b1, 1'b0, 64'h0,  32'h0,        1'b1, 1'b0, 32'h0,        64'h0};
    vt[12] = '{1'b0, 1'b0, 1'b0, 64'h0,      1'b1, 1'b0, 64'h0,  32'h0,        1'b1, 1'b1, 32'h11111111, 64'h14};
    vt[13] = '{1'b0, 1'b0, 1'b1, 64'h4010,   1'b1, 1'b0, 64'h0,  32'h0,        1'b1, 1'b0, 32'h0,        64'h0};
    vt[14] = '{1'b0, 1'b0, 1'b0, 64'h0,      1'b1, 1'b0, 64'h0,  32'h0,        1'b1, 1'b1, 32'h00208133, 64'h4010};
    vt[15] = '{1'b0, 1'b0, 1'b0, 64'h0,      1'b1, 1'b0, 64'h0,  32'h0,        1'b1, 1'b0, 32'h0,        64'h0};

    // Power-up reset for one edge before anything is checked.
    drv(1, 0, 0, 0, 1, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);

    // Directed table: basic fetches, write/read ordering, index wrap.
    for (int i = 0; i < 16; i++) begin
      drv(vt[i].rst, vt[i].flush, vt[i].rv, vt[i].ra, vt[i].rr, vt[i].we, vt[i].wa, vt[i].wd);
      #1;
      chk($sformatf("tbl%0d_ready", i), 64'(o_req_ready), 64'(vt[i].e_ready));
      chk($sformatf("tbl%0d_valid", i), 64'(o_rsp_valid), 64'(vt[i].e_valid));
      chk($sformatf("tbl%0d_instr", i), 64'(o_rsp_instr), 64'(vt[i].e_instr));
      chk($sformatf("tbl%0d_addr", i),  o_rsp_addr, vt[i].e_addr);
      step();
    end

    // Backpressure: requests are refused once FIFO_DEPTH are outstanding.
    n_acc = 0;
    for (int i = 0; i < FIFO_DEPTH + 4; i++) begin
      drv(0, 0, 1, 64'h100 + 64'(4 * i), 0, 0, 0, 0);
      #1;
      if (o_req_ready) n_acc++;
      step();
    end
    chk("bp_accepts", 64'(n_acc), 64'(FIFO_DEPTH));
    drv(0, 0, 0, 0, 1, 0, 0, 0);
    #1;
    chk("bp_ready_low", 64'(o_req_ready), 64'h0);
    step();
    #1;
    chk("bp_ready_back", 64'(o_req_ready), 64'h1);
    for (int i = 0; i < FIFO_DEPTH + 2; i++) step();

    // Flush with two fetches in flight and a request in the flush cycle.
    drv(0, 0, 1, 64'h200, 0, 0, 0, 0); step();
    drv(0, 0, 1, 64'h204, 0, 0, 0, 0); step();
    drv(0, 1, 1, 64'h208, 0, 0, 0, 0);
    #1;
    chk("flush_ready", 64'(o_req_ready), 64'h0);
    step();
    drv(0, 0, 0, 0, 1, 0, 0, 0);
    #1;
    chk("flush_empty", 64'(o_rsp_valid), 64'h0);
    step();
    drv(0, 0, 1, 64'h20C, 1, 0, 0, 0); step();
    drv(0, 0, 0, 0, 1, 0, 0, 0);
    lat = 1;
    while (!o_rsp_valid && lat < 10) begin step(); lat++; end
    chk("flush_latency", 64'(lat), 64'(LATENCY));
    chk("flush_addr", o_rsp_addr, 64'h20C);
    step();

    // Address 0x4000 wraps onto word 0.
    drv(0, 0, 0, 0, 1, 1, 64'h0, 32'hABCD0033); step();
    drv(0, 0, 1, 64'h4000, 1, 0, 0, 0); step();
    drv(0, 0, 0, 0, 1, 0, 0, 0);
    lat = 1;
    while (!o_rsp_valid && lat < 10) begin step(); lat++; end
    chk("wrap_instr", 64'(o_rsp_instr), 64'h00000000ABCD0033);
    step();

`ifdef IMEM_MISALIGN_FAULT_EN
    // Misaligned fetch returns a fault and a NOP.
    drv(0, 0, 1, 64'h6, 1, 0, 0, 0); step();
    drv(0, 0, 0, 0, 1, 0, 0, 0);
    lat = 1;
    while (!o_rsp_valid && lat < 10) begin step(); lat++; end
    chk("fault_flag", 64'(o_rsp_fault), 64'h1);
    chk("fault_instr", 64'(o_rsp_instr), 64'(NOP));
    step();
`endif

    // Reset with a full FIFO clears every output; no stale responses afterwards.
    for (int i = 0; i < FIFO_DEPTH + 2; i++) begin
      drv(0, 0, 1, 64'h300 + 64'(4 * i), 0, 0, 0, 0); step();
    end
    drv(1, 0, 1, 64'h400, 1, 0, 0, 0);
    #1;
    chk("rst_ready", 64'(o_req_ready), 64'h0);
    step();
    drv(0, 0, 0, 0, 1, 0, 0, 0);
    #1;
    chk("rst_valid", 64'(o_rsp_valid), 64'h0);
    chk("rst_instr", 64'(o_rsp_instr), 64'h0);
    chk("rst_addr",  o_rsp_addr, 64'h0);
    chk("rst_ready_after", 64'(o_req_ready), 64'h1);
    for (int i = 0; i < 4; i++) step();

    // Random traffic against the reference model.
    for (int i = 0; i < 800; i++) begin
      ra = 64'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) ra[63:32] = $urandom;
      if ($urandom_range(0, 7) == 0) ra[IW+1:8] = IW'($urandom);
      drv($urandom_range(0, 99) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0, ra,
          $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
          64'($urandom_range(0, 255)), $urandom);
      step();
    end
    drv(0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < LATENCY + FIFO_DEPTH + 2; i++) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
